// File: rtl/wb_spi_sram_responder.sv
// Wishbone classic slave turning each byte access into one mode-0 SPI
// READ/WRITE frame on a 23LC1024-style SRAM.
module wb_spi_sram_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [39:0]   tx_q;
  logic [7:0]    rx_q;
  logic [7:0]    dat_q;
  logic [5:0]    bit_q;
  logic [DW-1:0] div_q;
  logic          sck_q;
  logic          cs_n_q;
  logic          ack_q;
  logic          we_q;
  logic          abort_q;
  logic          req;

  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            tx_q    <= {wbs_we_i ? 8'h02 : 8'h03,
                        24'(wbs_adr_i),
                        wbs_we_i ? wbs_dat_i : 8'h00};
            we_q    <= wbs_we_i;
            bit_q   <= '0;
            div_q   <= '0;
            abort_q <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Frame always completes so the SRAM never sees a torn command
          if (!wbs_cyc_i) abort_q <= 1'b1;
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_q <= {rx_q[6:0], spi_miso_i};
            end else begin
              tx_q  <= {tx_q[38:0], 1'b0};
              bit_q <= bit_q + 6'd1;
              if (bit_q == 6'd39) begin
                cs_n_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_DONE: begin
          ack_q <= ~abort_q;
          if (!we_q && !abort_q) dat_q <= rx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = 1'b0;
  assign wbs_rty_o  = 1'b0;
  assign wbs_dat_o  = dat_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = tx_q[39];

endmodule

// File: tb/tb_wb_spi_sram_responder.sv
// Bench for wb_spi_sram_responder: two instances (CLK_DIV 1 and 3) against
// a behavioural SPI SRAM and a transaction-level reference.
module tb_wb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  dat = '0;

  logic       ack1, err1, rty1, cs1, sck1, mosi1;
  logic       ack3, err3, rty3, cs3, sck3, mosi3;
  logic [7:0] do1, do3;
  logic       m_cs, m_sck, m_mosi, m_ack, f_miso;
  logic       cyc1, cyc3;

  assign cyc1   = cyc & ~sel;
  assign cyc3   = cyc & sel;
  assign m_cs   = sel ? cs3 : cs1;
  assign m_sck  = sel ? sck3 : sck1;
  assign m_mosi = sel ? mosi3 : mosi1;
  assign m_ack  = sel ? ack3 : ack1;

  always #5 clk = ~clk;

  wb_spi_sram_responder #(.ADDR_WIDTH(24), .CLK_DIV(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb),
    .wbs_adr_i(adr), .wbs_we_i(we), .wbs_dat_i(dat),
    .wbs_ack_o(ack1), .wbs_err_o(err1), .wbs_rty_o(rty1),
    .wbs_dat_o(do1), .spi_cs_n_o(cs1), .spi_sck_o(sck1),
    .spi_mosi_o(mosi1), .spi_miso_i(f_miso)
  );

  wb_spi_sram_responder #(.ADDR_WIDTH(20), .CLK_DIV(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(stb),
    .wbs_adr_i(adr[19:0]), .wbs_we_i(we), .wbs_dat_i(dat),
    .wbs_ack_o(ack3), .wbs_err_o(err3), .wbs_rty_o(rty3),
    .wbs_dat_o(do3), .spi_cs_n_o(cs3), .spi_sck_o(sck3),
    .spi_mosi_o(mosi3), .spi_miso_i(f_miso)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
  endfunction

  // Behavioural SPI SRAM: decodes whole frames, mode 0
  logic [7:0]  sram [logic [23:0]];
  logic [39:0] fq[$];
  int          nq[$];
  logic [39:0] f_sr = '0;
  logic [7:0]  f_rd = '0;
  int          f_n = 40;
  int          f_p = 0;
  bit          f_on = 1'b0;
  bit          f_rdop = 1'b0;
  logic        mp_cs = 1'b1;
  logic        mp_sck = 1'b0;

  initial f_miso = 1'b0;

  always @(m_cs or m_sck) begin
    if (m_cs !== mp_cs) begin
      if (m_cs === 1'b0) begin
        f_n = 0; f_p = 0; f_sr = '0;
        f_rdop = 1'b0; f_miso = 1'b0; f_on = 1'b1;
      end else if (f_on) begin
        fq.push_back(f_sr);
        nq.push_back(f_p);
        f_on = 1'b0;
      end
    end
    if (m_sck !== mp_sck && m_cs === 1'b0) begin
      if (m_sck === 1'b1) begin
        f_p++;
        if (f_n < 40) begin
          f_sr = {f_sr[38:0], m_mosi};
          f_n++;
          if (f_n == 32) begin
            f_rdop = (f_sr[31:24] == 8'h03);
            f_rd = sram.exists(f_sr[23:0]) ? sram[f_sr[23:0]]
                                           : init_byte(f_sr[23:0]);
          end
          if (f_n == 40 && f_sr[39:32] == 8'h02)
            sram[f_sr[31:8]] = f_sr[7:0];
        end
      end else begin
        f_miso = (f_rdop && f_n >= 32 && f_n < 40) ? f_rd[39 - f_n] : 1'b0;
      end
    end
    mp_cs = m_cs;
    mp_sck = m_sck;
  end

  int   run = 0;
  bit   run_on = 1'b0;
  logic p_sck = 1'b0;
  int   ph_err = 0;
  int   gap = 100;
  int   last_gap = 100;
  int   gap_err = 0;
  int   ack_n = 0;

  always @(negedge clk) begin
    if (m_ack === 1'b1) ack_n++;
    if (m_cs === 1'b0) begin
      if (run_on && m_sck === p_sck) run++;
      else begin
        if (run_on && run != (sel ? 3 : 1)) ph_err++;
        run = 1;
        run_on = 1'b1;
      end
      p_sck = m_sck;
      if (gap > 0) begin
        last_gap = gap;
        if (gap < 2) gap_err++;
      end
      gap = 0;
    end else begin
      run_on = 1'b0;
      gap++;
    end
  end

  logic [7:0] exp_mem [logic [23:0]];
  logic [7:0] exp_dat [2];

  task automatic xfer(input bit s, input bit w, input logic [23:0] a,
                      input logic [7:0] d, input int abort_bit,
                      input bit keep);
    logic [23:0] ae;
    logic [39:0] fexp;
    int dv, lat, acks0, ph0, f0;
    bit ok;
    dv = s ? 3 : 1;
    ae = s ? {4'h0, a[19:0]} : a;
    fexp = {w ? 8'h02 : 8'h03, ae, w ? d : 8'h00};
    sel = s;
    acks0 = ack_n;
    ph0 = ph_err;
    f0 = fq.size();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_cs === 1'b0) begin ok = 1'b1; break; end
    end
    chk("accept", 64'(ok), 64'(1));
    adr = 24'($urandom);
    dat = 8'($urandom);
    we  = 1'($urandom);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 * dv; i++) begin
      @(negedge clk);
      lat++;
      if (abort_bit >= 0 && lat == 2 * abort_bit * dv + dv) begin
        cyc = 1'b0; stb = 1'b0;
      end
      if (m_ack === 1'b1) begin ok = 1'b1; break; end
    end
    if (abort_bit >= 0) chk("abort_noack", 64'(ok), 64'(0));
    else begin
      chk("ack_seen", 64'(ok), 64'(1));
      chk("latency", 64'(lat), 64'(1 + 80 * dv));
    end
    if (!keep) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
    @(negedge clk);
    chk("ack_pulse", 64'(m_ack), 64'(0));
    chk("frames", 64'(fq.size() - f0), 64'(1));
    if (fq.size() > f0) begin
      chk("sck_pulses", 64'(nq[f0]), 64'(40));
      chk("mosi_frame", 64'(fq[f0]), 64'(fexp));
    end
    chk("sck_phase", 64'(ph_err - ph0), 64'(0));
    if (w) begin
      exp_mem[ae] = d;
      chk("sram_byte", 64'(sram.exists(ae) ? sram[ae] : 8'hxx), 64'(d));
    end else if (abort_bit < 0) begin
      exp_dat[s] = exp_mem.exists(ae) ? exp_mem[ae] : init_byte(ae);
    end
    chk("dat_o", 64'(s ? do3 : do1), 64'(exp_dat[s]));
    chk("ack_count", 64'(ack_n - acks0), 64'(abort_bit < 0 ? 1 : 0));
  endtask

  logic [23:0] pool [8];
  int acks_b2b;
  bit ok_r;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    pool = '{24'h000123, 24'h800007, 24'h000000, 24'hFFFFFF,
             24'h0ABCDE, 24'h5F0F0F, 24'h000321, 24'h9FFFFF};
    exp_dat[0] = 8'h00;
    exp_dat[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs1", 64'(cs1), 64'(1));
    chk("rst_sck1", 64'(sck1), 64'(0));
    chk("rst_mosi1", 64'(mosi1), 64'(0));
    chk("rst_ack1", 64'(ack1), 64'(0));
    chk("rst_dat1", 64'(do1), 64'(0));
    chk("rst_cs3", 64'(cs3), 64'(1));
    chk("rst_dat3", 64'(do3), 64'(0));
    chk("rst_errrty", 64'({err1, rty1, err3, rty3}), 64'(0));

    xfer(1'b0, 1'b0, 24'h000123, 8'h00, -1, 1'b0);
    chk("t1_rd_a5", 64'(do1), 64'(8'hA5));
    xfer(1'b0, 1'b1, 24'h800007, 8'h5A, -1, 1'b0);
    chk("t2_dat_kept", 64'(do1), 64'(8'hA5));

    acks_b2b = ack_n;
    xfer(1'b0, 1'b0, pool[3], 8'h00, -1, 1'b1);
    xfer(1'b0, 1'b0, pool[4], 8'h00, -1, 1'b0);
    chk("t3_acks", 64'(ack_n - acks_b2b), 64'(2));
    chk("t3_gap_ge2", 64'(last_gap >= 2), 64'(1));

    xfer(1'b1, 1'b0, 24'h000123, 8'h00, -1, 1'b0);
    xfer(1'b1, 1'b0, 24'hFFFFFF, 8'h00, -1, 1'b0);

    sel = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000456;
    ok_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cs1 === 1'b0) begin ok_r = 1'b1; break; end
    end
    chk("t5_start", 64'(ok_r), 64'(1));
    repeat (40) @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_cs", 64'(cs1), 64'(1));
    chk("t5_sck", 64'(sck1), 64'(0));
    chk("t5_ack", 64'(ack1), 64'(0));
    exp_dat[0] = 8'h00;
    exp_dat[1] = 8'h00;
    chk("t5_dat", 64'(do1), 64'(0));
    @(negedge clk);
    xfer(1'b0, 1'b0, 24'h000456, 8'h00, -1, 1'b0);

    xfer(1'b0, 1'b1, 24'h000321, 8'hC3, 10, 1'b0);
    xfer(1'b0, 1'b0, 24'h000321, 8'h00, -1, 1'b0);
    chk("t6_readback", 64'(do1), 64'(8'hC3));

    for (int i = 0; i < 24; i++) begin
      xfer(i % 6 == 5, 1'($urandom), pool[$urandom_range(0, 7)],
           8'($urandom), (i % 7 == 3) ? int'($urandom_range(0, 39)) : -1,
           1'($urandom));
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(negedge clk);
    chk("cs_gap_min", 64'(gap_err), 64'(0));
    chk("end_errrty", 64'({err1, rty1, err3, rty3}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
